// File: rtl/ram_copy_pkg.sv
// Shared types and defaults for the RAM block-copy engine.
package ram_copy_pkg;
  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_DATA_W = 16;
  localparam logic [DEF_ADDR_W-1:0] ADDR_MASK = '1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
endpackage

// File: rtl/ram_copy_ptr.sv
// Loadable address pointer that increments modulo 2**ADDR_W.
// Exposes the next-cycle value so the owner can register outputs from it.
module ram_copy_ptr
  import ram_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr_next
);
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load)
      ptr_d = load_val;
    else if (inc)
      ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr_next = ptr_d;
endmodule

// File: rtl/ram_copy_engine.sv
// Word-by-word copy engine driving a Hack-style RAM port (two cycles per word).
// Define RAM_COPY_FILL_EN to add a 1 word/cycle fill mode selected by fill_mode.
module ram_copy_engine
  import ram_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              load_q, load_d;

  logic              accept, step;
  logic [ADDR_W-1:0] src_next, dst_next;
  logic              fill_sel_d;
  logic [DATA_W-1:0] fill_d;

  assign accept = (state_q == IDLE) && start;
  assign step   = (state_q == WRITE);

  ram_copy_ptr #(.ADDR_W(ADDR_W)) u_src_ptr (
    .clk      (CLK),
    .rst      (reset),
    .load     (accept),
    .load_val (src),
    .inc      (step),
    .ptr_next (src_next)
  );

  ram_copy_ptr #(.ADDR_W(ADDR_W)) u_dst_ptr (
    .clk      (CLK),
    .rst      (reset),
    .load     (accept),
    .load_val (dst),
    .inc      (step),
    .ptr_next (dst_next)
  );

`ifdef RAM_COPY_FILL_EN
  logic              fill_sel_q;
  logic [DATA_W-1:0] fill_q;

  always_comb begin
    fill_sel_d = fill_sel_q;
    fill_d     = fill_q;
    if (accept) begin
      fill_sel_d = fill_mode;
      fill_d     = fill_value;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      fill_sel_q <= 1'b0;
      fill_q     <= '0;
    end else begin
      fill_sel_q <= fill_sel_d;
      fill_q     <= fill_d;
    end
  end
`else
  logic unused_fill;
  assign fill_sel_d  = 1'b0;
  assign fill_d      = '0;
  assign unused_fill = ^{fill_mode, fill_value};
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = len;
          if (len == '0)
            state_d = DONE;
          else if (fill_sel_d)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        data_d  = mem_out;
        state_d = WRITE;
      end
      WRITE: begin
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == ADDR_W'(1))
          state_d = DONE;
        else if (fill_sel_d)
          state_d = WRITE;
        else
          state_d = READ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state and next pointers.
    busy_d  = (state_d == READ) || (state_d == WRITE);
    done_d  = (state_d == DONE);
    load_d  = (state_d == WRITE);
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == READ) begin
      addr_d = src_next;
    end else if (state_d == WRITE) begin
      addr_d  = dst_next;
      wdata_d = fill_sel_d ? fill_d : data_d;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_q      <= load_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign mem_load    = load_q;
endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural RAM16K on the mem_* port.
module tb_ram_copy_engine;
  import ram_copy_pkg::*;

  localparam int unsigned AW = DEF_ADDR_W;
  localparam int unsigned DW = DEF_DATA_W;
  localparam logic [DW-1:0] WA = 16'hA0A1, WB = 16'hB0B2, WC = 16'hC0C3,
                            WD = 16'hD0D4, WE = 16'hE0E5;

  logic          CLK = 1'b0;
  logic          reset, start, fill_mode;
  logic [AW-1:0] src, dst, len;
  logic [DW-1:0] fill_value;
  logic          busy, done, mem_load;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in, mem_out;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [AW-1:0] wa[$], ra[$];
  logic [DW-1:0] wd[$], exp_d[$];
  int checks = 0;
  int failures = 0;
  int da, bn, dn;
  logic [15:0] raw16;
  logic [AW-1:0] fill_dst;

  always #5 CLK = ~CLK;

  assign mem_out = ram[mem_address];
  always @(posedge CLK) if (mem_load) ram[mem_address] = mem_in;

  ram_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .fill_mode   (fill_mode),
    .fill_value  (fill_value),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (mem_load) begin
      check("load_with_busy", 32'(busy), 32'd1);
      wa.push_back(mem_address);
      wd.push_back(mem_in);
    end
    if (busy && !mem_load) ra.push_back(mem_address);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs;
    wa.delete();
    wd.delete();
    ra.delete();
  endtask

  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l,
                       input logic fm, input logic [DW-1:0] fv);
    src = s; dst = d; len = l; fill_mode = fm; fill_value = fv; start = 1'b1;
    tick;
    start = 1'b0; src = ~s; dst = ~d; len = ~l; fill_mode = ~fm; fill_value = ~fv;
  endtask

  // Sample n cycles starting right after the accepting edge; optionally pulse start at pulse_at.
  task automatic watch(input int n, input int pulse_at, output int done_at,
                       output int busy_n, output int done_n);
    done_at = -1; busy_n = 0; done_n = 0;
    for (int i = 0; i < n; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (i == pulse_at) begin
        start = 1'b1; src = 14'h0500; dst = 14'h0600; len = 14'd2;
      end else begin
        start = 1'b0;
      end
      tick;
    end
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [AW-1:0] a0, input int n);
    logic [AW-1:0] ea;
    check({tag, "_nwrites"}, 32'(wa.size()), 32'(n));
    for (int k = 0; k < n && k < wa.size(); k++) begin
      ea = a0 + AW'(k);
      check({tag, "_waddr"}, 32'(wa[k]), 32'(ea));
      check({tag, "_wdata"}, 32'(wd[k]), 32'(exp_d[k]));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    fill_mode = 1'b0; fill_value = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;

    tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_load", 32'(mem_load), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_in", 32'(mem_in), 32'd0);
    tick;
    reset = 1'b0;

    ram[14'h0100] = WA; ram[14'h0101] = WB; ram[14'h0102] = WC;
    ram[14'h0103] = WD; ram[14'h0104] = WE;

    // basic copy of 4 words
    clear_logs();
    issue(14'h0100, 14'h2000, 14'd4, 1'b0, 16'h0);
    watch(12, -1, da, bn, dn);
    check("t1_done_at", da, 8);
    check("t1_busy_n", bn, 8);
    check("t1_done_n", dn, 1);
    exp_d = '{WA, WB, WC, WD};
    check_writes("t1", 14'h2000, 4);
    check("t1_ram_2003", 32'(ram[14'h2003]), 32'(WD));
    check("t1_idle_addr", 32'(mem_address), 32'd0);

    // len = 0
    clear_logs();
    issue(14'h0100, 14'h2000, 14'd0, 1'b0, 16'h0);
    watch(4, -1, da, bn, dn);
    check("t2_done_at", da, 0);
    check("t2_busy_n", bn, 0);
    check("t2_done_n", dn, 1);
    check("t2_nwrites", 32'(wa.size()), 32'd0);

    // source pointer wrap
    ram[14'h3FFE] = 16'h1357; ram[14'h3FFF] = 16'h2468; ram[14'h0000] = 16'h3579;
    clear_logs();
    issue(14'h3FFE, 14'h1000, 14'd3, 1'b0, 16'h0);
    watch(10, -1, da, bn, dn);
    check("t3_done_at", da, 6);
    check("t3_nreads", 32'(ra.size()), 32'd3);
    if (ra.size() == 3) begin
      check("t3_read0", 32'(ra[0]), 32'h3FFE);
      check("t3_read1", 32'(ra[1]), 32'h3FFF);
      check("t3_read2", 32'(ra[2]), 32'h0000);
    end
    exp_d = '{16'h1357, 16'h2468, 16'h3579};
    check_writes("t3", 14'h1000, 3);

    // destination pointer wrap
    ram[14'h0800] = 16'h4A4A; ram[14'h0801] = 16'h5B5B;
    clear_logs();
    issue(14'h0800, 14'h3FFF, 14'd2, 1'b0, 16'h0);
    watch(8, -1, da, bn, dn);
    check("t3b_done_at", da, 4);
    exp_d = '{16'h4A4A, 16'h5B5B};
    check_writes("t3b", 14'h3FFF, 2);
    check("t3b_ram_0000", 32'(ram[14'h0000]), 32'h5B5B);

    // start re-pulsed mid-copy is ignored
    clear_logs();
    issue(14'h0100, 14'h2400, 14'd4, 1'b0, 16'h0);
    watch(12, 3, da, bn, dn);
    check("t4_done_at", da, 8);
    check("t4_busy_n", bn, 8);
    check("t4_done_n", dn, 1);
    exp_d = '{WA, WB, WC, WD};
    check_writes("t4", 14'h2400, 4);

    // overlapping forward copy replicates the first word; start during DONE ignored
    ram[14'h0700] = 16'h6C6C; ram[14'h0701] = 16'h0001;
    ram[14'h0702] = 16'h0002; ram[14'h0703] = 16'h0003;
    clear_logs();
    issue(14'h0700, 14'h0701, 14'd3, 1'b0, 16'h0);
    watch(10, 6, da, bn, dn);
    check("ovl_done_at", da, 6);
    check("ovl_busy_n", bn, 6);
    check("ovl_done_n", dn, 1);
    exp_d = '{16'h6C6C, 16'h6C6C, 16'h6C6C};
    check_writes("ovl", 14'h0701, 3);

    // reset in WRITE of word 2 of 4
    ram[14'h0200] = 16'h0C01; ram[14'h0201] = 16'h0C02;
    ram[14'h0202] = 16'h0C03; ram[14'h0203] = 16'h0C04;
    for (int i = 0; i < 4; i++) ram[14'h0300 + i] = 16'hDEAD;
    clear_logs();
    issue(14'h0200, 14'h0300, 14'd4, 1'b0, 16'h0);
    tick; tick; tick;
    check("t5_in_write2", 32'(mem_load), 32'd1);
    check("t5_write2_addr", 32'(mem_address), 32'h0301);
    reset = 1'b1;
    #1;
    check("t5_load_drop", 32'(mem_load), 32'd0);
    check("t5_busy_drop", 32'(busy), 32'd0);
    check("t5_addr_clr", 32'(mem_address), 32'd0);
    tick;
    reset = 1'b0;
    watch(4, -1, da, bn, dn);
    check("t5_no_done", dn, 0);
    check("t5_ram_0300", 32'(ram[14'h0300]), 32'h0C01);
    check("t5_ram_0301", 32'(ram[14'h0301]), 32'hDEAD);
    check("t5_nwrites", 32'(wa.size()), 32'd1);
    clear_logs();
    issue(14'h0200, 14'h0300, 14'd4, 1'b0, 16'h0);
    watch(12, -1, da, bn, dn);
    check("t5b_done_at", da, 8);
    check("t5b_done_n", dn, 1);
    exp_d = '{16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04};
    check_writes("t5b", 14'h0300, 4);

    // fill request (a copy in the default build)
    raw16 = 16'h4000;
    fill_dst = raw16[AW-1:0] & ADDR_MASK;
    clear_logs();
    issue(14'h0100, fill_dst, 14'd5, 1'b1, 16'hFFFF);
    watch(14, -1, da, bn, dn);
`ifdef RAM_COPY_FILL_EN
    check("t6_done_at", da, 5);
    check("t6_busy_n", bn, 5);
    check("t6_nreads", 32'(ra.size()), 32'd0);
    exp_d = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`else
    check("t6_done_at", da, 10);
    check("t6_busy_n", bn, 10);
    check("t6_nreads", 32'(ra.size()), 32'd5);
    exp_d = '{WA, WB, WC, WD, WE};
`endif
    check("t6_done_n", dn, 1);
    check_writes("t6", 14'h0000, 5);
    check("t6_ram_0004", 32'(ram[14'h0004]), 32'(exp_d[4]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
